i2s_receiver: RTL and testbench
===============================

# i2s_receiver

Deserializes a standard Philips I2S stream (bit clock, word select, serial data) into parallel left/right sample pairs in the system `clk` domain. It is the receive-side counterpart of `i2s_transmitter`. Its first use is loopback verification of the synth's DAC path. Its second use is capturing an external ADC stream for future audio-input features. Completed frames are presented on a valid/ready handshake, with a sticky overflow flag and a lock indicator.

## Interface
- `NUM_BITS`, 24, sample word width; matches the DAC word width.
- `SYNC_STAGES`, 2, flip-flop stages on each asynchronous input (minimum 2).
- `TIMEOUT`, 1024, `clk` cycles without a bit-clock rising edge before lock is dropped.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  synchronous, active-high reset.
- `s_clk`  in  1  external I2S bit clock (asynchronous to `clk`).
- `word_select`  in  1  I2S WS: 0 = left, 1 = right.
- `serial_data`  in  1  I2S SD, MSB first.
- `left_out`  out  `NUM_BITS`  left sample of the current frame.
- `right_out`  out  `NUM_BITS`  right sample of the current frame.
- `out_valid`  out  1  frame available.
- `out_ready`  in  1  consumer accepts the frame.
- `locked`  out  1  receiver is aligned to frame boundaries.
- `overflow`  out  1  sticky flag: a frame was dropped.
- `ovf_clr`  in  1  one-cycle pulse that clears `overflow`.

## Operation
- **Input synchronization**
  - `s_clk`, `word_select` and `serial_data` each pass through `SYNC_STAGES` flops.
  - A rising-edge detect on the synchronized `s_clk` produces a one-cycle strobe `bit_stb`.
  - All remaining logic advances only on `bit_stb`.
- **Sampling on each `bit_stb`**
  - Sample `sd` and `ws`.
  - Set channel `ch` = `ws` sampled at the previous `bit_stb`. This implements the one-bit I2S delay.
  - Store `ch` as `last_ch`.
- **Slot boundary:** occurs when `ch != last_ch`. The current bit is then the MSB of the new slot.
- **Bit placement**
  - The bit counter resets to 0 at each boundary.
  - Bit number n is written to shift position `NUM_BITS-1-n`.
  - The counter saturates at `NUM_BITS`. Bits beyond `NUM_BITS` are discarded.
  - Short slots are zero-padded in the LSBs, so words are always left-justified.
- **States**
  - `UNLOCKED`:
    - Reset state.
    - On a boundary into `ch=0`, go to `LEFT` and start collecting.
    - Boundaries into `ch=1` are ignored.
  - `LEFT`:
    - On a boundary into `ch=1`, latch the left word into a holding register, then go to `RIGHT`.
  - `RIGHT`:
    - On a boundary into `ch=0`, the frame is complete: commit the held left word and the right word, then go to `LEFT`.
- **Lock**
  - `locked` = 1 in `LEFT`/`RIGHT`, 0 in `UNLOCKED`.
  - A partial frame collected before lock is never emitted.
- **Timeout**
  - A counter is cleared on every `bit_stb`.
  - When it reaches `TIMEOUT`, the FSM returns to `UNLOCKED`.
  - Any in-progress frame is discarded. A pending output is unaffected.
- **Output handshake**
  - On commit with `out_valid`=0: load `left_out`/`right_out` and set `out_valid`=1.
  - With `out_valid`=1 and `out_ready`=1: clear `out_valid`, unless a commit occurs in the same cycle.
  - Commit and accept in the same cycle: load the new frame and keep `out_valid`=1.
  - Commit while `out_valid`=1 and `out_ready`=0: drop the new frame, keep the old data, set `overflow`=1.
  - Outputs are stable while `out_valid`=1.
- **Overflow flag**
  - `overflow` is cleared by `ovf_clr`.
  - If `ovf_clr` and a new overflow occur in the same cycle, the set wins.

## Timing
- **Reset values:** `left_out`=0, `right_out`=0, `out_valid`=0, `locked`=0, `overflow`=0. In addition, state = `UNLOCKED`, counters = 0, and sampled `ws` history = 0.
- **`bit_stb` latency:** `bit_stb` is asserted `SYNC_STAGES`+1 `clk` cycles after an external `s_clk` rising edge.
- **Input constraints**
  - `s_clk` high and low phases must each be at least `SYNC_STAGES`+1 `clk` cycles.
  - The sender changes WS and SD on the falling edge of `s_clk`.
- **Commit latency**
  - `out_valid` rises 1 `clk` cycle after the `bit_stb` that detects the left-slot boundary.
  - From the external `s_clk` edge, this is `SYNC_STAGES`+2 cycles.
- **Lock latency:**
  - `locked` rises 1 cycle after the first left-boundary `bit_stb`.
  - `locked` falls 1 cycle after the timeout count is reached.
- **Accepted-frame throughput:** at most one accepted frame per I2S frame period.
- **Reset mid-frame:** all state is cleared on the next `clk` edge. No partial output is produced.

## Test plan
- **Basic frame:** with lock established, send L=`24'hA5C3F1`, R=`24'h1234AB` in 24-bit slots, `s_clk` = `clk`/8, `out_ready`=1.
  - Expect `left_out`=A5C3F1 and `right_out`=1234AB.
  - Expect `out_valid` pulses for 1 cycle, 4 cycles after the `s_clk` edge that carries the next left MSB.
- **Lock acquisition:** start the stream mid right slot.
  - Expect no `out_valid` until one full L/R pair has been received after the first WS 1→0 transition.
  - Expect `locked` to rise on that first transition.
- **Slot length mismatch:**
  - 32-bit slots carrying L=`32'hDEADBEEF` → `left_out`=`24'hDEADBE`.
  - 16-bit slots carrying L=`16'h8001` → `left_out`=`24'h800100`.
- **Backpressure:** hold `out_ready`=0 over 2 frames.
  - Expect frame 1 retained, `overflow`=1 after frame 2.
  - Then assert `ovf_clr` → `overflow`=0.
  - Then `out_ready`=1 → frame 1 is accepted.
- **Simultaneous accept and commit:** assert `out_ready` in the same cycle as the next commit.
  - Expect new data loaded, `out_valid` remains 1, `overflow` remains 0.
- **Timeout and reset:** stop `s_clk` for 1100 `clk` cycles → `locked`=0.
  - Resume the stream → relock on the next left boundary.
  - Assert `rst` mid slot → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/i2s_receiver.sv
// Philips I2S receiver: synchronizes the bit clock, word select and data into clk,
// tracks slot boundaries and presents left/right frames on a valid/ready handshake.
module i2s_receiver #(
  parameter int NUM_BITS    = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_clk,
  input  logic                word_select,
  input  logic                serial_data,
  output logic [NUM_BITS-1:0] left_out,
  output logic [NUM_BITS-1:0] right_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                locked,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_POS = CW'(NUM_BITS - 1);

  typedef enum logic [1:0] {UNLOCKED, LEFT, RIGHT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, ws_sync, sd_sync;
  logic                   sclk_prev, bit_stb, ws_bit, sd_bit;
  logic                   ws_prev, last_ch, ch, boundary, commit;
  logic [CW-1:0]          bit_cnt;
  logic [TW-1:0]          to_cnt;
  logic [NUM_BITS-1:0]    shreg, hold_left;
  state_t                 state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ws_sync   <= '0;
      sd_sync   <= '0;
      sclk_prev <= 1'b0;
      bit_stb   <= 1'b0;
      ws_bit    <= 1'b0;
      sd_bit    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], s_clk};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], word_select};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], serial_data};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      bit_stb   <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
      ws_bit    <= ws_sync[SYNC_STAGES-1];
      sd_bit    <= sd_sync[SYNC_STAGES-1];
    end
  end

  // The channel of the current bit is WS from the previous bit (one-bit I2S delay).
  always_comb begin
    ch       = ws_prev;
    boundary = (ch != last_ch);
    commit   = bit_stb && boundary && !ch && (state == RIGHT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws_prev   <= 1'b0;
      last_ch   <= 1'b0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      shreg     <= '0;
      hold_left <= '0;
      state     <= UNLOCKED;
      locked    <= 1'b0;
    end else if (bit_stb) begin
      to_cnt  <= '0;
      ws_prev <= ws_bit;
      last_ch <= ch;
      if (boundary) begin
        shreg   <= {sd_bit, {(NUM_BITS-1){1'b0}}};
        bit_cnt <= CW'(1);
      end else if (bit_cnt < CW'(NUM_BITS)) begin
        shreg[LAST_POS - bit_cnt] <= sd_bit;
        bit_cnt                   <= bit_cnt + 1'b1;
      end
      if (boundary) begin
        case (state)
          UNLOCKED: if (!ch) begin
            state  <= LEFT;
            locked <= 1'b1;
          end
          LEFT: if (ch) begin
            hold_left <= shreg;
            state     <= RIGHT;
          end
          RIGHT: if (!ch) state <= LEFT;
          default: begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end
        endcase
      end
    end else if (to_cnt == TW'(TIMEOUT)) begin
      state  <= UNLOCKED;
      locked <= 1'b0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // A commit that meets a full, un-accepted output buffer is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_out  <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (commit && (!out_valid || out_ready)) begin
        left_out  <= hold_left;
        right_out <= shreg;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (commit && out_valid && !out_ready) overflow <= 1'b1;
      else if (ovf_clr)                      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed/randomized bench for i2s_receiver: frames are built slot-by-slot and
// expected words come from a left-justify model of each slot's value and width.
module tb_i2s_receiver;

  logic        clk = 1'b0, rst = 1'b1;
  logic        s_clk = 1'b0, word_select = 1'b0, serial_data = 1'b0;
  logic        out_ready = 1'b0, ovf_clr = 1'b0;
  logic [23:0] left_out, right_out;
  logic        out_valid, locked, overflow;

  int tests = 0, failed = 0;
  int cyc = 0, rise_cyc = 0, last_lat = -1, last_width = -1, hi_cnt = 0;
  bit prev_valid = 1'b0;
  logic [47:0] acc_q[$];
  logic [31:0] fl[12], fr[12];
  int          fw[12];

  always #5 clk = ~clk;

  i2s_receiver dut (
    .clk(clk), .rst(rst), .s_clk(s_clk), .word_select(word_select),
    .serial_data(serial_data), .left_out(left_out), .right_out(right_out),
    .out_valid(out_valid), .out_ready(out_ready), .locked(locked),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: records accepted frames, valid-rise latency and pulse width.
  always @(negedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (!prev_valid) last_lat = cyc - rise_cyc;
      hi_cnt++;
      if (out_ready === 1'b1) acc_q.push_back({left_out, right_out});
    end else if (prev_valid) begin
      last_width = hi_cnt;
      hi_cnt     = 0;
    end
    prev_valid = (out_valid === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Left-justified 24-bit word carried by a slot of the given width.
  function automatic logic [23:0] fmt(logic [31:0] v, int w);
    logic [63:0] x;
    x = {32'd0, v} & ((64'd1 << w) - 64'd1);
    if (w >= 24) x = x >> (w - 24);
    else         x = x << (24 - w);
    return x[23:0];
  endfunction

  function automatic logic [47:0] expf(int k);
    return {fmt(fl[k], fw[k]), fmt(fr[k], fw[k])};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(logic w, logic d);
    s_clk = 1'b0; word_select = w; serial_data = d;
    repeat (4) @(negedge clk);
    s_clk = 1'b1; rise_cyc = cyc;
    repeat (4) @(negedge clk);
  endtask

  // WS switches to the next channel one bit before that channel's MSB.
  task automatic send_slot(logic [31:0] v, int width, int first, int count,
                           logic ch, logic next_ch);
    for (int i = first; i < first + count; i++)
      send_bit((i == width - 1) ? next_ch : ch, v[width-1-i]);
  endtask

  task automatic body(int k, int from);
    send_slot(fl[k], fw[k], from, fw[k] - from, 1'b0, 1'b1);
    send_slot(fr[k], fw[k], 0, fw[k], 1'b1, 1'b0);
  endtask

  task automatic trigger(int k);
    send_slot(fl[k], fw[k], 0, 1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [47:0] got;
    logic [31:0] t;
    int          n;

    for (int k = 0; k < 12; k++) begin
      fl[k] = $urandom; fr[k] = $urandom; fw[k] = 24;
    end
    fl[1] = 32'h00A5C3F1; fr[1] = 32'h001234AB;
    fl[2] = 32'hDEADBEEF; fw[2] = 32;
    fl[3] = 32'h00008001; fw[3] = 16;

    repeat (3) @(negedge clk);
    check("rst_left", left_out, 0);
    check("rst_right", right_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // Lock acquisition: stream starts in the middle of a right slot.
    send_slot($urandom, 24, 14, 10, 1'b1, 1'b0);
    check("lock_before", locked, 0);
    trigger(0);
    check("lock_rise", locked, 1);
    check("no_partial", acc_q.size(), 0);
    body(0, 1);
    check("no_early_valid", acc_q.size(), 0);
    trigger(1);
    check("frame0_count", acc_q.size(), 1);
    check("frame0", acc_q[$], expf(0));

    // Basic frame with commit latency and pulse width.
    last_width = -1;
    body(1, 1); trigger(2);
    got = acc_q[$];
    check("basic_left", got[47:24], 24'hA5C3F1);
    check("basic_right", got[23:0], 24'h1234AB);
    check("basic_latency", last_lat, 4);
    check("basic_width", last_width, 1);

    body(2, 1); trigger(3);
    got = acc_q[$];
    check("slot32_left", got[47:24], 24'hDEADBE);
    check("slot32_frame", got, expf(2));

    body(3, 1); trigger(4);
    got = acc_q[$];
    check("slot16_left", got[47:24], 24'h800100);
    check("slot16_frame", got, expf(3));

    // Backpressure across two frames.
    out_ready = 1'b0;
    body(4, 1); trigger(5);
    check("bp_valid", out_valid, 1);
    check("bp_frame1", {left_out, right_out}, expf(4));
    check("bp_no_ovf", overflow, 0);
    body(5, 1); trigger(6);
    check("bp_ovf_set", overflow, 1);
    check("bp_retained", {left_out, right_out}, expf(4));
    n = acc_q.size();
    ovf_clr = 1'b1; @(negedge clk);
    ovf_clr = 1'b0; @(negedge clk);
    check("bp_ovf_clr", overflow, 0);
    out_ready = 1'b1; @(negedge clk);
    check("bp_valid_drop", out_valid, 0);
    check("bp_accept_count", acc_q.size(), n + 1);
    check("bp_accept_frame", acc_q[$], expf(4));

    // Accept and commit in the same cycle.
    out_ready = 1'b0;
    body(6, 1); trigger(7);
    body(7, 1);
    t = fl[8];
    s_clk = 1'b0; word_select = 1'b0; serial_data = t[23];
    repeat (4) @(negedge clk);
    s_clk = 1'b1; rise_cyc = cyc;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("sim_valid", out_valid, 1);
    check("sim_frame", {left_out, right_out}, expf(7));
    check("sim_no_ovf", overflow, 0);
    @(negedge clk);
    check("sim_valid_drop", out_valid, 0);
    repeat (2) @(negedge clk);
    check("sim_old_accepted", acc_q[$-1], expf(6));
    check("sim_new_accepted", acc_q[$], expf(7));

    // Bit clock stalls long enough to lose lock, then the stream resumes.
    repeat (990) @(negedge clk);
    check("to_still_locked", locked, 1);
    repeat (110) @(negedge clk);
    check("to_unlocked", locked, 0);
    n = acc_q.size();
    body(8, 0);
    check("relock_wait", locked, 0);
    trigger(9);
    check("relock", locked, 1);
    check("relock_no_commit", acc_q.size(), n);
    body(9, 1); trigger(10);
    check("relock_count", acc_q.size(), n + 1);
    check("relock_frame", acc_q[$], expf(9));

    // Reset in the middle of a slot with a frame pending.
    out_ready = 1'b0;
    body(10, 1); trigger(11);
    check("pre_rst_valid", out_valid, 1);
    send_slot(fl[11], 24, 1, 5, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_left", left_out, 0);
    check("mid_rst_right", right_out, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_overflow", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
